// File: rtl/tail_light_sequencer.sv
// Tail-light sequencer: turns left/right/hazard requests into the lamp-state code
// stepped at a prescaled rate, with busy and end-of-sequence status.
module tail_light_sequencer #(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = $clog2(TICK_DIV + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  output logic [3:0] present_state,
  output logic       step_tick,
  output logic       busy,
  output logic       seq_done
);

  typedef enum logic [3:0] {
    S0 = 4'd0,
    L1 = 4'd1, L2 = 4'd2, L3 = 4'd3, L4 = 4'd4,  L5 = 4'd5,
    R1 = 4'd6, R2 = 4'd7, R3 = 4'd8, R4 = 4'd9,  R5 = 4'd10,
    S1 = 4'd11
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_step;
  logic             r_done;
  logic             w_tick;
  logic             w_illegal;
  logic             w_ends_seq;

  assign w_tick     = en && (r_cnt == LAST);
  assign w_illegal  = (r_state > S1);
  assign w_ends_seq = (r_state == L5) || (r_state == R5) || (r_state == S1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S0: begin
        if (hazard || (left && right)) w_next = S1;
        else if (left)                 w_next = L1;
        else if (right)                w_next = R1;
        else                           w_next = S0;
      end
      S1: w_next = S0;
      L1, L2, L3, L4: begin
        if (hazard)      w_next = S1;
        else if (right)  w_next = S0;
        else if (!left)  w_next = S0;
        else             w_next = state_t'(r_state + 4'd1);
      end
      R1, R2, R3, R4: begin
        if (hazard)      w_next = S1;
        else if (left)   w_next = S0;
        else if (!right) w_next = S0;
        else             w_next = state_t'(r_state + 4'd1);
      end
      L5, R5:  w_next = S0;
      default: w_next = S0;
    endcase
  end

  // Illegal codes recover on the next edge regardless of the prescaler.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S0;
      r_cnt   <= '0;
      r_step  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_step <= w_tick;
      r_done <= w_tick && w_ends_seq;
      if (en) r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      if (w_tick || w_illegal) r_state <= w_next;
    end
  end

  assign present_state = r_state;
  assign step_tick     = r_step;
  assign seq_done      = r_done;
  assign busy          = (r_state != S0);

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Directed bench for tail_light_sequencer: TICK_DIV=4 instance for the sequence tests,
// TICK_DIV=1 instance for the every-cycle stepping case.
module tb_tail_light_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, en, left, right, hazard;
  logic [3:0] ps;
  logic       stp, bsy, done;

  logic       rst1_n, en1, left1, right1, hazard1;
  logic [3:0] ps1;
  logic       stp1, bsy1, done1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [3:0]  exp_prev;

  always #5 clk = ~clk;

  tail_light_sequencer #(.TICK_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .left(left), .right(right), .hazard(hazard),
    .present_state(ps), .step_tick(stp), .busy(bsy), .seq_done(done)
  );

  tail_light_sequencer #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .en(en1), .left(left1), .right(right1), .hazard(hazard1),
    .present_state(ps1), .step_tick(stp1), .busy(bsy1), .seq_done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  // Three non-tick cycles then a tick cycle; assumes the prescaler is at 0 on entry.
  task automatic tick_step(input logic [3:0] es, input logic ed, input string tag);
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      check({tag, "_hold_state"}, ps, exp_prev);
      check({tag, "_hold_tick"}, stp, 0);
      check({tag, "_hold_done"}, done, 0);
      check({tag, "_hold_busy"}, bsy, exp_prev != 4'd0);
    end
    edge_wait();
    check({tag, "_state"}, ps, es);
    check({tag, "_tick"}, stp, 1);
    check({tag, "_done"}, done, ed);
    check({tag, "_busy"}, bsy, es != 4'd0);
    exp_prev = es;
  endtask

  initial begin
    logic [3:0] seq1 [7];
    logic       dn1  [7];
    seq1 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
    dn1  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; en = 1'b1; left = 1'b1; right = 1'b0; hazard = 1'b0;
    rst1_n = 1'b0; en1 = 1'b1; left1 = 1'b0; right1 = 1'b0; hazard1 = 1'b0;
    exp_prev = 4'd0;

    // 1: reset with left held
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      check("rst_state", ps, 0);
      check("rst_busy", bsy, 0);
      check("rst_tick", stp, 0);
      check("rst_done", done, 0);
    end
    rst_n = 1'b1;

    // 2: left held, repeating pass
    tick_step(4'd1, 1'b0, "left1");
    tick_step(4'd2, 1'b0, "left2");
    tick_step(4'd3, 1'b0, "left3");
    tick_step(4'd4, 1'b0, "left4");
    tick_step(4'd5, 1'b0, "left5");
    tick_step(4'd0, 1'b1, "left_end");
    tick_step(4'd1, 1'b0, "left_rep");
    left = 1'b0;
    tick_step(4'd0, 1'b0, "left_abort");

    // 3: hazard flashing, then left+right acts as hazard
    hazard = 1'b1;
    tick_step(4'd11, 1'b0, "haz_on1");
    tick_step(4'd0, 1'b1, "haz_off1");
    tick_step(4'd11, 1'b0, "haz_on2");
    hazard = 1'b0; left = 1'b1; right = 1'b1;
    tick_step(4'd0, 1'b1, "haz_off2");
    tick_step(4'd11, 1'b0, "lr_on");
    left = 1'b0; right = 1'b0;
    tick_step(4'd0, 1'b1, "lr_off");

    // request pulse between ticks is ignored
    edge_wait();
    left = 1'b1;
    edge_wait();
    left = 1'b0;
    edge_wait();
    edge_wait();
    check("glitch_state", ps, 0);
    check("glitch_tick", stp, 1);

    // 4: hazard raised mid left sequence
    left = 1'b1;
    tick_step(4'd1, 1'b0, "lh1");
    tick_step(4'd2, 1'b0, "lh2");
    tick_step(4'd3, 1'b0, "lh3");
    hazard = 1'b1;
    tick_step(4'd11, 1'b0, "lh_haz");
    hazard = 1'b0; left = 1'b0;
    tick_step(4'd0, 1'b1, "lh_off");

    // 5: right dropped at R2, enable frozen with prescaler at its last count
    right = 1'b1;
    tick_step(4'd6, 1'b0, "r1");
    tick_step(4'd7, 1'b0, "r2");
    right = 1'b0;
    for (int i = 0; i < 3; i++) edge_wait();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edge_wait();
      check("frz_state", ps, 7);
      check("frz_tick", stp, 0);
    end
    en = 1'b1;
    edge_wait();
    check("resume_state", ps, 0);
    check("resume_tick", stp, 1);
    check("resume_done", done, 0);
    exp_prev = 4'd0;

    // 6: reset pulse mid right sequence clears state and prescaler
    right = 1'b1;
    tick_step(4'd6, 1'b0, "rr1");
    tick_step(4'd7, 1'b0, "rr2");
    tick_step(4'd8, 1'b0, "rr3");
    edge_wait();
    edge_wait();
    rst_n = 1'b0;
    edge_wait();
    check("rpulse_state", ps, 0);
    check("rpulse_busy", bsy, 0);
    check("rpulse_tick", stp, 0);
    rst_n = 1'b1;
    exp_prev = 4'd0;
    tick_step(4'd6, 1'b0, "post_rst");
    right = 1'b0;
    tick_step(4'd0, 1'b0, "post_abort");

    // TICK_DIV=1: every enabled cycle steps
    edge_wait();
    rst1_n = 1'b1; left1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      edge_wait();
      check("d1_state", ps1, seq1[i]);
      check("d1_tick", stp1, 1);
      check("d1_done", done1, dn1[i]);
    end
    en1 = 1'b0;
    edge_wait();
    check("d1_frz_state", ps1, 1);
    check("d1_frz_tick", stp1, 0);
    en1 = 1'b1; left1 = 1'b0;
    edge_wait();
    check("d1_abort_state", ps1, 0);
    check("d1_abort_done", done1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
